// File: rtl/icache_refill_responder.sv
// Memory-side refill endpoint for the instruction cache: accepts one line request,
// waits a fixed latency, then streams the line critical-word-first with valid/ready.
module icache_refill_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 16,
  parameter int LATENCY    = 4,
  parameter int MEM_BYTES  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              kill_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
  localparam int LANES      = DATA_W / 32;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int BOFF_W     = $clog2(BEAT_BYTES);
  localparam int IDX_W      = $clog2(BEATS);
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [ADDR_W-1:0]  r_base;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_rsp_valid;
  logic               r_rsp_last;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_busy;

  logic               w_req_ready;
  logic               w_accept;
  logic               w_beat_hs;
  logic               w_last_hs;
  logic               w_go_idle;
  logic [ADDR_W-1:0]  w_line_base;
  logic [IDX_W-1:0]   w_start_idx;
  logic               w_addr_err;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic [DATA_W-1:0]  w_beat_data;
  logic               w_unused_addr;

  assign w_req_ready = (r_state == ST_IDLE) & ~kill_i;
  assign w_accept    = req_valid_i & w_req_ready;
  assign w_beat_hs   = r_rsp_valid & rsp_ready_i;
  assign w_last_hs   = (r_state == ST_BURST) & w_beat_hs & (r_cnt == IDX_W'(BEATS - 1));
  assign w_go_idle   = (r_state != ST_IDLE) & (kill_i | w_last_hs);

  assign w_line_base   = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_start_idx   = req_addr_i[OFF_W-1:BOFF_W];
  assign w_addr_err    = (64'(req_addr_i) >= 64'(MEM_BYTES));
  assign w_unused_addr = &{1'b0, req_addr_i[BOFF_W-1:0]};

  // The first beat uses the latched start index; later beats wrap modulo BEATS
  // through the natural overflow of the index register.
  assign w_nxt_idx = (r_state == ST_BURST) ? (r_idx + IDX_W'(1)) : r_idx;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_beat_data[32*gi +: 32] = 32'(r_base) + 32'(w_nxt_idx) * 32'(BEAT_BYTES) + 32'(4 * gi);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_base      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else if (w_go_idle) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_WAIT;
            r_base     <= w_line_base;
            r_idx      <= w_start_idx;
            r_err      <= w_addr_err;
            r_cnt      <= '0;
            r_wait_cnt <= CNT_W'(LATENCY - 1);
            r_busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state     <= ST_BURST;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= r_err;
            r_rsp_data  <= r_err ? '0 : w_beat_data;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        ST_BURST: begin
          if (w_beat_hs) begin
            r_idx      <= w_nxt_idx;
            r_cnt      <= r_cnt + IDX_W'(1);
            r_rsp_last <= (r_cnt == IDX_W'(BEATS - 2));
            r_rsp_data <= r_err ? '0 : w_beat_data;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_last_o  = r_rsp_last;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for icache_refill_responder: directed refill scenarios plus a randomized
// phase, all checked every cycle against a transaction-level model of the responder.
module tb_icache_refill_responder;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int LINE_BYTES = 16;
  localparam int LATENCY    = 4;
  localparam int MEM_BYTES  = 4096;
  localparam int BB         = DATA_W / 8;
  localparam int BEATS      = LINE_BYTES / BB;
  localparam int LANES      = DATA_W / 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              kill = 1'b0;
  logic              rsp_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_last;
  logic              rsp_err;
  logic              busy;
  logic [DATA_W-1:0] rsp_data;

  icache_refill_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES),
    .LATENCY(LATENCY), .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .kill_i(kill),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_last_o(rsp_last), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Transaction-level model: a line is outstanding from acceptance until kill
  // or the BEATS-th handshake; beats become visible LATENCY edges after acceptance.
  logic        m_busy = 1'b0;
  int          edge_n = 0;
  int          m_first = 0;
  int          m_done = 0;
  int          m_start = 0;
  logic [31:0] m_base = '0;
  logic        m_err = 1'b0;
  logic        exp_valid;

  assign exp_valid = m_busy && (edge_n >= m_first);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      edge_n  <= 0;
      m_first <= 0;
      m_done  <= 0;
    end else begin
      edge_n <= edge_n + 1;
      if (!m_busy) begin
        if (req_valid && !kill) begin
          m_busy  <= 1'b1;
          m_base  <= req_addr & ~(LINE_BYTES - 1);
          m_start <= int'((req_addr / BB) % BEATS);
          m_err   <= (req_addr >= MEM_BYTES);
          m_first <= edge_n + 1 + LATENCY;
          m_done  <= 0;
        end
      end else if (kill) begin
        m_busy <= 1'b0;
      end else if (exp_valid && rsp_ready) begin
        m_done <= m_done + 1;
        if (m_done + 1 == BEATS) m_busy <= 1'b0;
      end
    end
  end

  function automatic logic [DATA_W-1:0] exp_data();
    logic [DATA_W-1:0] d;
    d = '0;
    if (!m_err) begin
      for (int k = 0; k < LANES; k++)
        d[32*k +: 32] = m_base + 32'(((m_start + m_done) % BEATS) * BB) + 32'(4 * k);
    end
    return d;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
    logic              e;
  } beat_t;
  beat_t got[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, exp_valid);
      chk("req_ready", req_ready, !m_busy && !kill);
      if (exp_valid) begin
        chk("rsp_data", rsp_data, exp_data());
        chk("rsp_last", rsp_last, (m_done == BEATS - 1));
        chk("rsp_err", rsp_err, m_err);
      end else begin
        chk("rsp_last_idle", rsp_last, 1'b0);
      end
      if (rsp_valid && rsp_ready) begin
        got.push_back('{d: rsp_data, l: rsp_last, e: rsp_err});
        $display("beat data=%h last=%0b err=%0b", rsp_data, rsp_last, rsp_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
    tick();
    req_valid = 1'b0;
    $display("request addr=%h accepted", a);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
    chk("ready_after_line", req_ready, 1'b1);
  endtask

  task automatic chk_two(input string tag, input logic [63:0] d0, input logic [63:0] d1,
                         input logic e);
    chk({tag, "_nbeats"}, 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk({tag, "_d0"}, got[0].d, d0);
      chk({tag, "_l0"}, got[0].l, 1'b0);
      chk({tag, "_e0"}, got[0].e, e);
      chk({tag, "_d1"}, got[1].d, d1);
      chk({tag, "_l1"}, got[1].l, 1'b1);
      chk({tag, "_e1"}, got[1].e, e);
    end
  endtask

  initial begin
    int n;
    logic [63:0] held;

    @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_last", rsp_last, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_data", rsp_data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;

    got.delete();
    send(32'h100);
    wait_valid(n);
    chk("latency_100", 64'(n), 64'(4));
    wait_idle();
    chk_two("a100", 64'h0000010C_00000108 ^ 64'h0000010C_00000108 ^ 64'h00000104_00000100,
            64'h0000010C_00000108, 1'b0);

    got.delete();
    send(32'h10A);
    wait_idle();
    chk_two("a10A", 64'h0000010C_00000108, 64'h00000104_00000100, 1'b0);

    got.delete();
    rsp_ready = 1'b0;
    send(32'h200);
    wait_valid(n);
    chk("stall_first", rsp_data, 64'h00000204_00000200);
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_data, held);
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk_two("a200", 64'h00000204_00000200, 64'h0000020C_00000208, 1'b0);

    got.delete();
    send(32'h300);
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", busy, 1'b0);
    chk("kill_valid", rsp_valid, 1'b0);
    repeat (6) tick();
    chk("kill_nbeats", 64'(got.size()), 64'(0));
    send(32'h340);
    wait_idle();
    chk_two("a340", 64'h00000344_00000340, 64'h0000034C_00000348, 1'b0);

    got.delete();
    send(32'h1000);
    wait_idle();
    chk_two("a1000", 64'h0, 64'h0, 1'b1);

    rsp_ready = 1'b0;
    send(32'h180);
    wait_valid(n);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 1'b0);
    chk("arst_last", rsp_last, 1'b0);
    chk("arst_err", rsp_err, 1'b0);
    chk("arst_data", rsp_data, 64'h0);
    chk("arst_busy", busy, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("arst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    got.delete();
    send(32'h140);
    wait_valid(n);
    chk("latency_140", 64'(n), 64'(4));
    wait_idle();
    chk_two("a140", 64'h00000144_00000140, 64'h0000014C_00000148, 1'b0);

    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 32'($urandom_range(0, 32'h17FF));
      kill      = ($urandom_range(0, 15) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    kill      = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for the instruction-cache refill interface.
- Accepts one line-refill request at a time from the cache's miss handler.
- Waits a fixed access latency, then returns the line as a multi-beat burst, critical word first, with valid/ready flow control.
- Replaces the untimed memory stub in cache-level benches and serves as the refill endpoint at the cache boundary.

Parameters:
- ADDR_W, 32, request address width in bits.
- DATA_W, 64, response beat width in bits; must be a multiple of 32.
- LINE_BYTES, 16, cache line size in bytes; BEATS = LINE_BYTES/(DATA_W/8), must be ≥2 and a power of 2.
- LATENCY, 4, cycles from request acceptance to first rsp_valid_o; must be ≥1.
- MEM_BYTES, 4096, size of the addressable region; addresses ≥ MEM_BYTES are errors.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  refill request valid
- req_ready_o  out  1  responder can accept a request
- req_addr_i  in  ADDR_W  requested byte address (any alignment)
- kill_i  in  1  abort the outstanding refill (cache flush or redirect)
- rsp_valid_o  out  1  response beat valid
- rsp_ready_i  in  1  cache accepts beat
- rsp_data_o  out  DATA_W  beat data
- rsp_last_o  out  1  final beat of the line
- rsp_err_o  out  1  address out of range; asserted on every beat of the line
- busy_o  out  1  request outstanding (state != IDLE)

Behaviour:
- FSM states: IDLE, WAIT, BURST.
- Reset (async assert): state=IDLE, counters=0, rsp_valid_o=0, rsp_last_o=0, rsp_err_o=0, rsp_data_o=0, busy_o=0.
- req_ready_o is combinational: req_ready_o = (state==IDLE) & ~kill_i.
- IDLE:
  - Request accepted on req_valid_i & req_ready_o.
  - On acceptance latch: line base = addr with low log2(LINE_BYTES) bits cleared; start beat = addr[log2(LINE_BYTES)-1 : log2(DATA_W/8)]; err = (addr ≥ MEM_BYTES).
  - Load wait counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, go to BURST.
  - First rsp_valid_o is therefore visible exactly LATENCY cycles after the accepting edge.
- BURST:
  - rsp_valid_o=1.
  - Beat index starts at the start beat and advances by 1 modulo BEATS on each rsp_valid_o & rsp_ready_i. This is the wrap-around that gives critical-word-first order.
  - Beat count runs 0..BEATS-1; rsp_last_o = (count==BEATS-1).
  - rsp_data_o, rsp_last_o and rsp_err_o hold stable while rsp_ready_i=0.
  - Handshake on the last beat goes to IDLE; req_ready_o rises the next cycle. There is no same-cycle back-to-back acceptance.
- Data pattern, so refills are checkable without preload:
  - Each 32-bit lane k of a beat = byte address of that lane, i.e. line base + beat index*(DATA_W/8) + 4k, truncated to 32 bits.
  - If err is set, rsp_data_o = 0 on every beat.
- kill_i:
  - In WAIT or BURST, go to IDLE on the next edge. rsp_valid_o and rsp_last_o drop that edge, and no further beats are issued.
  - A beat handshaking in the same cycle as kill_i counts as consumed, but the line is abandoned.
  - In IDLE, kill_i blocks acceptance (req_ready_o=0) and has no other effect.
- Output registers: rsp_* outputs are registered from FSM state; only req_ready_o is combinational.
- busy_o = (state != IDLE), registered.
- Reset asserted mid-WAIT or mid-BURST returns immediately to reset values. The outstanding request is lost.
- Request inputs are ignored outside IDLE. Holding req_valid_i high while busy has no effect until IDLE.

Test Plan:
- Defaults, req addr 0x100 accepted at edge 0 → rsp_valid_o first high after edge 4; beat0 data 0x00000104_00000100, last=0; beat1 0x0000010C_00000108, last=1; err=0; req_ready_o=1 one cycle after the last handshake.
- Req addr 0x10A → critical word first: beat0 0x0000010C_00000108, beat1 0x00000104_00000100 with last=1.
- Req 0x200; hold rsp_ready_i=0 for 3 cycles during beat0 → rsp_valid_o stays 1 and data stays 0x00000204_00000200 unchanged; the burst completes normally after ready.
- Req 0x300, assert kill_i 2 cycles after accept → no rsp_valid_o ever; busy_o falls the next cycle. A following req 0x340 returns 0x00000344_00000340 and 0x0000034C_00000348.
- Req 0x1000 (= MEM_BYTES) → two beats, rsp_err_o=1 on both, data 0, last on the second.
- Assert rst_ni low during beat0 of the burst → all outputs 0 asynchronously. After release req_ready_o=1, and a new request is served with full LATENCY.
